// File: rtl/ball_pkg.sv
// Shared types and helpers for the ball motion peripheral.
// Optional wall-hit interrupt is enabled with BALL_MOTION_IRQ_EN.
package ball_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FRAME,
        STEP,
        COMMIT
    } state_t;

    localparam logic [2:0] ADDR_X_INIT  = 3'd0;
    localparam logic [2:0] ADDR_Y_INIT  = 3'd1;
    localparam logic [2:0] ADDR_VX      = 3'd2;
    localparam logic [2:0] ADDR_VY      = 3'd3;
    localparam logic [2:0] ADDR_CTRL    = 3'd4;
    localparam logic [2:0] ADDR_IRQ_CLR = 3'd5;
    localparam logic [2:0] ADDR_CNT_LO  = 3'd6;
    localparam logic [2:0] ADDR_CNT_HI  = 3'd7;

    localparam logic [7:0] DEF_X = 8'd80;
    localparam logic [7:0] DEF_Y = 8'd60;

    localparam int DEF_MAX_SPEED = 15;

    function automatic logic [7:0] clamp_speed(
        input logic [7:0] v,
        input int         lim
    );
        int s;
        s = int'($signed(v));
        if (s > lim)  return 8'(lim);
        if (s < -lim) return 8'(-lim);
        return v;
    endfunction

    function automatic logic [7:0] clamp_pos(
        input logic [7:0] v,
        input int         lo,
        input int         hi
    );
        int u;
        u = int'(v);
        if (u > hi) return 8'(hi);
        if (u < lo) return 8'(lo);
        return v;
    endfunction

endpackage

// File: rtl/ball_axis_step.sv
// One-axis step: advance position by velocity, reflect off the walls.
module ball_axis_step #(
    parameter int MIN = 0,
    parameter int MAX = 255
) (
    input  logic [7:0]        pos,
    input  logic signed [7:0] vel,
    output logic [7:0]        pos_next,
    output logic signed [7:0] vel_next,
    output logic              hit
);

    localparam logic signed [9:0] LO = 10'(MIN);
    localparam logic signed [9:0] HI = 10'(MAX);

    logic signed [9:0] sum;

    always_comb begin
        sum      = $signed({2'b00, pos}) + $signed({{2{vel[7]}}, vel});
        pos_next = sum[7:0];
        vel_next = vel;
        hit      = 1'b0;
        if (sum > HI) begin
            pos_next = HI[7:0];
            vel_next = -vel;
            hit      = 1'b1;
        end else if (sum < LO) begin
            pos_next = LO[7:0];
            vel_next = -vel;
            hit      = 1'b1;
        end
    end

endmodule

// File: rtl/ball_motion.sv
// Avalon-MM ball position/velocity engine, stepped once per video frame.
// Define BALL_MOTION_IRQ_EN for the wall-hit irq and bounce counter.
module ball_motion
    import ball_pkg::*;
#(
    parameter int XMIN        = 4,
    parameter int XMAX        = 155,
    parameter int YMIN        = 4,
    parameter int YMAX        = 115,
    parameter int MAX_SPEED   = DEF_MAX_SPEED,
    parameter int FRAME_DIV_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       chipselect,
    input  logic       write,
    input  logic       read,
    input  logic [2:0] address,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    input  logic       frame_tick,
    output logic [7:0] ball_x,
    output logic [7:0] ball_y,
    output logic       irq
);

    state_t state;

    logic [7:0]        x_init, y_init;
    logic signed [7:0] vx_sh, vy_sh;
    logic [7:0]        pos_x, pos_y;
    logic signed [7:0] vx, vy;
    logic              run, load_pending;
    logic [FRAME_DIV_W-1:0] div, div_cnt;

    logic [7:0]        nx, ny;
    logic signed [7:0] nvx, nvy;
    logic              hit_x, hit_y;
    logic              wr_en, rd_en, do_load;
    logic [7:0]        rd_data;

`ifdef BALL_MOTION_IRQ_EN
    logic [15:0] bounce_cnt;
`endif

    ball_axis_step #(.MIN(XMIN), .MAX(XMAX)) u_step_x (
        .pos      (pos_x),
        .vel      (vx),
        .pos_next (nx),
        .vel_next (nvx),
        .hit      (hit_x)
    );

    ball_axis_step #(.MIN(YMIN), .MAX(YMAX)) u_step_y (
        .pos      (pos_y),
        .vel      (vy),
        .pos_next (ny),
        .vel_next (nvy),
        .hit      (hit_y)
    );

    assign wr_en = chipselect && write;
    assign rd_en = chipselect && read;
    // A pending load is honoured on a tick whether or not the ball runs
    assign do_load = frame_tick && load_pending &&
                     (state == IDLE || (state == WAIT_FRAME && run));

    always_comb begin
        rd_data = 8'h00;
        unique case (address)
            ADDR_X_INIT: rd_data = ball_x;
            ADDR_Y_INIT: rd_data = ball_y;
            ADDR_VX:     rd_data = vx;
            ADDR_VY:     rd_data = vy;
            ADDR_CTRL:   rd_data = 8'({div, 2'b00, load_pending, run});
`ifdef BALL_MOTION_IRQ_EN
            ADDR_IRQ_CLR: rd_data = {7'b0, irq};
            ADDR_CNT_LO:  rd_data = bounce_cnt[7:0];
            ADDR_CNT_HI:  rd_data = bounce_cnt[15:8];
`else
            ADDR_IRQ_CLR, ADDR_CNT_LO, ADDR_CNT_HI: rd_data = 8'h00;
`endif
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            x_init       <= DEF_X;
            y_init       <= DEF_Y;
            vx_sh        <= '0;
            vy_sh        <= '0;
            pos_x        <= DEF_X;
            pos_y        <= DEF_Y;
            vx           <= '0;
            vy           <= '0;
            ball_x       <= DEF_X;
            ball_y       <= DEF_Y;
            run          <= 1'b0;
            load_pending <= 1'b0;
            div          <= '0;
            div_cnt      <= '0;
            readdata     <= '0;
        end else begin
            if (rd_en) readdata <= rd_data;
            if (do_load) begin
                pos_x        <= clamp_pos(x_init, XMIN, XMAX);
                pos_y        <= clamp_pos(y_init, YMIN, YMAX);
                vx           <= vx_sh;
                vy           <= vy_sh;
                load_pending <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (do_load)  state <= COMMIT;
                    else if (run) state <= WAIT_FRAME;
                end
                WAIT_FRAME: begin
                    if (!run) begin
                        state <= IDLE;
                    end else if (frame_tick) begin
                        if (do_load) begin
                            state <= COMMIT;
                        end else if (div_cnt == div) begin
                            div_cnt <= '0;
                            state   <= STEP;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                end
                STEP: begin
                    pos_x <= nx;
                    pos_y <= ny;
                    vx    <= nvx;
                    vy    <= nvy;
                    state <= COMMIT;
                end
                COMMIT: begin
                    ball_x <= pos_x;
                    ball_y <= pos_y;
                    state  <= run ? WAIT_FRAME : IDLE;
                end
            endcase
            // Placed after the FSM so a new load request beats a load clear
            if (wr_en) begin
                unique case (address)
                    ADDR_X_INIT: x_init <= writedata;
                    ADDR_Y_INIT: y_init <= writedata;
                    ADDR_VX:     vx_sh  <= clamp_speed(writedata, MAX_SPEED);
                    ADDR_VY:     vy_sh  <= clamp_speed(writedata, MAX_SPEED);
                    ADDR_CTRL: begin
                        run <= writedata[0];
                        if (writedata[1]) load_pending <= 1'b1;
                        div <= writedata[4 +: FRAME_DIV_W];
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef BALL_MOTION_IRQ_EN
    // Set is evaluated last so a hit beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            irq        <= 1'b0;
            bounce_cnt <= '0;
        end else begin
            if (wr_en && address == ADDR_IRQ_CLR) irq <= 1'b0;
            if (state == STEP && (hit_x || hit_y)) begin
                irq        <= 1'b1;
                bounce_cnt <= bounce_cnt + 16'd1;
            end
        end
    end
`else
    logic unused_hits;
    assign unused_hits = hit_x | hit_y;
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_ball_motion.sv
// Randomized bench for ball_motion against a frame-level reference model.
// Expectations follow BALL_MOTION_IRQ_EN when it is defined.
module tb_ball_motion;

    logic       clk = 1'b0;
    logic       reset;
    logic       chipselect;
    logic       write;
    logic       read;
    logic [2:0] address;
    logic [7:0] writedata;
    logic [7:0] readdata;
    logic       frame_tick;
    logic [7:0] ball_x;
    logic [7:0] ball_y;
    logic       irq;

    int total = 0;
    int bad   = 0;

    // reference model state
    int sx, sy, svx, svy;
    int mx, my, mvx, mvy;
    int bx, by;
    int run, pend, div, cnt;
    int irq_m, bnc;

    always #5 clk = ~clk;

    ball_motion dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .frame_tick (frame_tick),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .irq        (irq)
    );

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int clampv(input int d);
        int v;
        v = (d > 127) ? d - 256 : d;
        if (v > 15)  v = 15;
        if (v < -15) v = -15;
        return v;
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction

    function automatic int exp_irq();
`ifdef BALL_MOTION_IRQ_EN
        return irq_m;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_cnt();
`ifdef BALL_MOTION_IRQ_EN
        return bnc;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        sx = 80; sy = 60; svx = 0; svy = 0;
        mx = 80; my = 60; mvx = 0; mvy = 0;
        bx = 80; by = 60;
        run = 0; pend = 0; div = 0; cnt = 0;
        irq_m = 0; bnc = 0;
    endtask

    task automatic axis(input int p, input int v, input int lo, input int hi,
                        output int np, output int nv, output bit h);
        np = p + v; nv = v; h = 0;
        if (np > hi) begin np = hi; nv = -v; h = 1; end
        else if (np < lo) begin np = lo; nv = -v; h = 1; end
    endtask

    task automatic model_tick();
        bit hx, hy;
        if (pend != 0) begin
            mx = clampi(sx, 4, 155); my = clampi(sy, 4, 115);
            mvx = svx; mvy = svy; pend = 0;
            bx = mx; by = my;
        end else if (run != 0) begin
            if (cnt == div) begin
                cnt = 0;
                axis(mx, mvx, 4, 155, mx, mvx, hx);
                axis(my, mvy, 4, 115, my, mvy, hy);
                if (hx || hy) begin irq_m = 1; bnc = (bnc + 1) % 65536; end
                bx = mx; by = my;
            end else begin
                cnt = (cnt + 1) % 16;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic wr(input int a, input int d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1;
        address = 3'(a); writedata = 8'(d);
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
        case (a)
            0: sx = d;
            1: sy = d;
            2: svx = clampv(d);
            3: svy = clampv(d);
            4: begin
                run = d & 1;
                if (((d >> 1) & 1) != 0) pend = 1;
                div = (d >> 4) & 15;
            end
            5: irq_m = 0;
            default: ;
        endcase
    endtask

    task automatic rd(input int a, output logic [7:0] d);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = 3'(a);
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        model_tick();
    endtask

    task automatic check_all(input string tag);
        logic [7:0] d;
        check({tag, ".x"}, 16'(ball_x), 16'(bx));
        check({tag, ".y"}, 16'(ball_y), 16'(by));
        rd(2, d); check({tag, ".vx"}, 16'(d), 16'(mvx & 255));
        rd(3, d); check({tag, ".vy"}, 16'(d), 16'(mvy & 255));
        rd(4, d);
        check({tag, ".ctrl"}, 16'(d), 16'((div << 4) | (pend << 1) | run));
        rd(5, d); check({tag, ".irqreg"}, 16'(d), 16'(exp_irq()));
        check({tag, ".irq"}, 16'(irq), 16'(exp_irq()));
    endtask

    initial begin
        logic [7:0] d;
        int old_x, old_vx;
        reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
        address = '0; writedata = '0; frame_tick = 1'b0;
        model_reset();
        do_reset();

        // reset state
        check("rst.readdata", 16'(readdata), 16'd0);
        check("rst.x", 16'(ball_x), 16'd80);
        check("rst.y", 16'(ball_y), 16'd60);
        check_all("rst");

        // basic motion
        wr(0, 20); wr(1, 30); wr(2, 2); wr(3, 8'hFF); wr(4, 8'h03);
        tick(); check("t1.x", 16'(ball_x), 16'd20); check("t1.y", 16'(ball_y), 16'd30);
        tick(); check("t2.x", 16'(ball_x), 16'd22); check("t2.y", 16'(ball_y), 16'd29);
        tick(); check("t3.x", 16'(ball_x), 16'd24); check("t3.y", 16'(ball_y), 16'd28);
        check_all("t3");

        // write VX in the STEP cycle; exact output latency
        old_x = bx; old_vx = mvx;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        chipselect = 1'b1; write = 1'b1; address = 3'd2; writedata = 8'd5;
        @(negedge clk); chipselect = 1'b0; write = 1'b0;
        check("lat.hold", 16'(ball_x), 16'(old_x));
        svx = 5;
        model_tick();
        @(negedge clk);
        check("lat.new", 16'(ball_x), 16'd26);
        rd(2, d); check("stepwr.vx", 16'(d), 16'(old_vx & 255));
        check_all("stepwr");

        // reset during COMMIT
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check("rstc.x", 16'(ball_x), 16'd80);
        check("rstc.y", 16'(ball_y), 16'd60);
        model_reset();
        check_all("rstc");

        // right wall bounce
        wr(0, 154); wr(2, 3); wr(4, 8'h03);
        tick(); check("wl.load", 16'(ball_x), 16'd154);
        tick(); check("wl.hit", 16'(ball_x), 16'd155);
        rd(2, d); check("wl.vx", 16'(d), 16'hFD);
        check_all("wl");
        tick(); check("wl.back", 16'(ball_x), 16'd152);
        wr(5, 0);
        check_all("wl.clr");

        // frame divider
        wr(2, 1); wr(4, 8'h23); tick();
        for (int i = 0; i < 6; i++) begin
            tick(); check_all("div");
        end
        wr(2, 100); wr(4, 8'h03); tick();
        rd(2, d); check("vclamp", 16'(d), 16'd15);
        wr(2, 8'h80); wr(4, 8'h03); tick();
        rd(2, d); check("vclamp.neg", 16'(d), 16'hF1);

        // corner hit
        wr(0, 4); wr(1, 4); wr(2, 8'hFE); wr(3, 8'hFE); wr(4, 8'h03);
        tick(); tick();
        check("cor.x", 16'(ball_x), 16'd4);
        check("cor.y", 16'(ball_y), 16'd4);
        rd(2, d); check("cor.vx", 16'(d), 16'd2);
        rd(3, d); check("cor.vy", 16'(d), 16'd2);
        rd(6, d); check("cor.cntlo", 16'(d), 16'(exp_cnt() & 255));
        rd(7, d); check("cor.cnthi", 16'(d), 16'((exp_cnt() >> 8) & 255));

        // randomized traffic
        for (int i = 0; i < 80; i++) begin
            int op;
            op = int'($urandom_range(0, 11));
            case (op)
                0: wr(0, int'($urandom_range(0, 255)));
                1: wr(1, int'($urandom_range(0, 255)));
                2: wr(2, int'($urandom_range(0, 255)));
                3: wr(3, int'($urandom_range(0, 255)));
                4: wr(4, (int'($urandom_range(0, 2)) << 4) |
                         (int'($urandom_range(0, 1)) << 1) |
                         (($urandom_range(0, 3) != 0) ? 1 : 0));
                5: wr(5, 0);
                default: begin tick(); check_all("rnd"); end
            endcase
        end
        rd(6, d); check("rnd.cntlo", 16'(d), 16'(exp_cnt() & 255));
        rd(7, d); check("rnd.cnthi", 16'(d), 16'((exp_cnt() >> 8) & 255));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
